usb_sdi_tx: RTL and testbench
=============================

Name: usb_sdi_tx

Overview:
- Avalon-MM slave that serialises bytes onto the USB controller's serial data-in line (usb_sdi) with an accompanying serial clock (usb_sck) and chip-select (usb_scs).
- Transmit-side counterpart of the existing USB serial-data-out input port.
- Sits on the Nios system bus; software writes a byte, polls busy, and reads the response bit through the existing input port.
- SPI mode 0, MSB first, programmable bit rate.

Parameters:
- DIV_DEFAULT, 4, reset value of the divider register: clk cycles per sck half-period (1..255).
- SCS_DEFAULT, 1, reset level of usb_scs (1 = deasserted).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- usb_sck  output  1  serial clock to the USB controller.
- usb_sdi  output  1  serial data to the USB controller.
- usb_scs  output  1  chip-select to the USB controller.

Behaviour:
- Reset (asynchronous, active-high) forces the following; no transfer is in progress after reset.
  - readdata = 0, usb_sck = 0, usb_sdi = 1, usb_scs = SCS_DEFAULT.
  - busy = 0, overrun = 0, divider = DIV_DEFAULT, state = IDLE.
- Register map. Unused bits read 0.
  - addr 0 TXDATA: write loads bits [7:0] and starts a transfer; reads return the last byte written.
  - addr 1 STATUS: bit0 = busy (read-only), bit1 = overrun. Writing 1 to bit1 clears overrun; all other bits are ignored.
  - addr 2 DIVIDER: bits [7:0], R/W. A value of 0 is treated as 1.
  - addr 3 CONTROL: bit0 = usb_scs level, R/W, applied on the cycle after the write.
- Reads: readdata updates every cycle from the addressed register (1-cycle latency); no read side effects.
- Write strobe condition: chipselect = 1 and write_n = 0, sampled at the clk edge.
- State machine:
  - IDLE: usb_sck = 0, usb_sdi = 1.
    - A TXDATA write loads shreg = writedata[7:0], bit_cnt = 7, cnt = 0, and sets busy.
    - Next cycle: usb_sdi = shreg[7], go to LOW.
  - LOW: usb_sck = 0. When cnt reaches div-1: cnt = 0, usb_sck = 1, go to HIGH.
  - HIGH: usb_sck = 1. The receiver samples on this rising edge. When cnt reaches div-1:
    - cnt = 0, usb_sck = 0.
    - If bit_cnt = 0: go to IDLE, busy = 0, usb_sdi = 1.
    - Else: shift shreg left, usb_sdi = new MSB, bit_cnt decremented, go to LOW.
- Timing: one byte occupies 16*div cycles from the first LOW cycle. busy is high from the cycle after the write through the final HIGH half-period.
- The divider is sampled at transfer start. DIVIDER writes during a transfer take effect on the next transfer.
- TXDATA write while busy: ignored (shreg and the stored byte are unchanged), overrun = 1.
- If a TXDATA write and an overrun clear arrive in the same cycle (separate cycles only on Avalon): each is handled independently per its address; no special case.
- usb_scs is purely software controlled and is independent of busy. Changing it mid-transfer does not abort the shift.
- Reset mid-transfer aborts immediately to the reset values above; no partial byte completes.

Test Plan:
- Reset: assert reset mid-cycle -> readdata = 0, usb_sck = 0, usb_sdi = 1, usb_scs = 1; read DIVIDER -> 4; read STATUS -> 0.
- Basic transfer, div = 4: write TXDATA = 0xA5 -> 8 rising sck edges, period 8 clk; bits sampled at the rising edges = 1,0,1,0,0,1,0,1. busy is high for exactly 64 cycles, then usb_sdi returns to 1.
- Divider edge values:
  - DIVIDER = 0 -> 0x3C sent with sck period 2 clk, busy for 16 cycles.
  - DIVIDER = 255 -> sck period 510 clk.
- Overrun: write 0x11, then write 0x22 while busy -> only 0x11 is shifted; STATUS reads 0x3. Write STATUS = 0x2 -> STATUS reads 0x1 while busy, 0x0 after completion.
- Chip-select: write CONTROL = 0 -> usb_scs = 0 next cycle; transfer 0xFF -> usb_sdi held 1 for all bits; CONTROL = 1 mid-transfer -> usb_scs = 1 and the shift completes.
- Reset mid-transfer: reset after 3 bits of 0x80 -> outputs at reset values; busy = 0. A new write of 0x01 transfers correctly.

Source files
------------

// File: rtl/usb_sdi_tx.sv
// usb_sdi_tx: Avalon-MM slave that shifts bytes out to the USB controller
// over usb_sck/usb_sdi (SPI mode 0, MSB first) with a software-driven usb_scs.
module usb_sdi_tx #(
  parameter int unsigned DIV_DEFAULT = 32'd4,
  parameter logic        SCS_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_sck,
  output logic        usb_sdi,
  output logic        usb_scs
);

  localparam logic [7:0] LP_DIV_RST = 8'(DIV_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // shifter / FSM state
  state_t      r_state,   w_state_nxt;
  logic [7:0]  r_shreg,   w_shreg_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_cnt,     w_cnt_nxt;
  logic [7:0]  r_div_act, w_div_act_nxt;
  logic        r_busy,    w_busy_nxt;
  logic        r_sck,     w_sck_nxt;
  logic        r_sdi,     w_sdi_nxt;

  // software-visible registers
  logic        r_overrun;
  logic [7:0]  r_div;
  logic        r_scs;
  logic [7:0]  r_txbyte;
  logic [31:0] r_readdata;

  logic        w_wr;
  logic        w_wr_tx;
  logic        w_wr_st;
  logic        w_wr_div;
  logic        w_wr_ctl;
  logic        w_start;
  logic        w_half_done;
  logic        w_unused_bits;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_tx     = w_wr & (address == 2'd0);
  assign w_wr_st     = w_wr & (address == 2'd1);
  assign w_wr_div    = w_wr & (address == 2'd2);
  assign w_wr_ctl    = w_wr & (address == 2'd3);
  // a TXDATA write only launches a byte when the shifter is free
  assign w_start     = w_wr_tx & ~r_busy;
  // the divider is latched at start, so mid-transfer DIVIDER writes wait
  assign w_half_done = (r_cnt == (r_div_act - 8'd1));
  assign w_unused_bits = ^writedata[31:8];

  // FSM state and shifter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shreg   <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_cnt     <= 8'd0;
      r_div_act <= 8'd1;
      r_busy    <= 1'b0;
      r_sck     <= 1'b0;
      r_sdi     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_act <= w_div_act_nxt;
      r_busy    <= w_busy_nxt;
      r_sck     <= w_sck_nxt;
      r_sdi     <= w_sdi_nxt;
    end
  end

  // next-state and registered-output logic for the bit shifter
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_cnt_nxt     = r_cnt;
    w_div_act_nxt = r_div_act;
    w_busy_nxt    = r_busy;
    w_sck_nxt     = r_sck;
    w_sdi_nxt     = r_sdi;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_shreg_nxt   = writedata[7:0];
          w_bit_cnt_nxt = 3'd7;
          w_cnt_nxt     = 8'd0;
          w_div_act_nxt = (r_div == 8'd0) ? 8'd1 : r_div;
          w_busy_nxt    = 1'b1;
          w_sck_nxt     = 1'b0;
          w_sdi_nxt     = writedata[7];
          w_state_nxt   = ST_LOW;
        end else begin
          w_sck_nxt = 1'b0;
          w_sdi_nxt = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_half_done) begin
          w_cnt_nxt   = 8'd0;
          w_sck_nxt   = 1'b1;
          w_state_nxt = ST_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_HIGH: begin
        if (w_half_done) begin
          w_cnt_nxt = 8'd0;
          w_sck_nxt = 1'b0;
          if (r_bit_cnt == 3'd0) begin
            w_busy_nxt  = 1'b0;
            w_sdi_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_shreg_nxt   = {r_shreg[6:0], 1'b0};
            w_sdi_nxt     = r_shreg[6];
            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
            w_state_nxt   = ST_LOW;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_sck_nxt   = 1'b0;
        w_sdi_nxt   = 1'b1;
      end
    endcase
  end

  // software register writes: stored byte, overrun flag, divider, chip-select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_div     <= LP_DIV_RST;
      r_scs     <= SCS_DEFAULT;
      r_txbyte  <= 8'd0;
    end else begin
      if (w_start) begin
        r_txbyte <= writedata[7:0];
      end
      if (w_wr_tx & r_busy) begin
        r_overrun <= 1'b1;
      end else if (w_wr_st & writedata[1]) begin
        r_overrun <= 1'b0;
      end
      if (w_wr_div) begin
        r_div <= writedata[7:0];
      end
      if (w_wr_ctl) begin
        r_scs <= writedata[0];
      end
    end
  end

  // registered read mux, refreshed every cycle from the addressed register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else begin
      case (address)
        2'd0:    r_readdata <= {24'd0, r_txbyte};
        2'd1:    r_readdata <= {30'd0, r_overrun, r_busy};
        2'd2:    r_readdata <= {24'd0, r_div};
        2'd3:    r_readdata <= {31'd0, r_scs};
        default: r_readdata <= 32'd0;
      endcase
    end
  end

  assign readdata = r_readdata;
  assign usb_sck  = r_sck;
  assign usb_sdi  = r_sdi;
  assign usb_scs  = r_scs;

endmodule

// File: tb/tb_usb_sdi_tx.sv
// tb_usb_sdi_tx: directed + random stimulus for usb_sdi_tx against a
// timeline model of the serial line and the register map.
module tb_usb_sdi_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        usb_sck;
  logic        usb_sdi;
  logic        usb_scs;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  usb_sdi_tx #(.DIV_DEFAULT(32'd4), .SCS_DEFAULT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .usb_sck    (usb_sck),
    .usb_sdi    (usb_sdi),
    .usb_scs    (usb_scs)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A byte accepted at clock edge m_start occupies 16*m_div edges; at t edges
  // later bit t/(2*div) is on the line, and sck is high in the second half.
  int          m_cyc;
  int          m_start;
  int          m_div;
  bit          m_active;
  bit          m_ovr;
  logic [7:0]  m_byte;
  logic [7:0]  m_tx;
  logic [7:0]  m_divreg;
  logic        m_scs;
  logic [31:0] m_rd;

  function automatic bit m_busy();
    return m_active && ((m_cyc - m_start) < 16 * m_div);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ovr    = 1'b0;
    m_divreg = 8'd4;
    m_scs    = 1'b1;
    m_rd     = 32'd0;
    m_tx     = 8'd0;
    m_byte   = 8'd0;
    m_div    = 1;
    m_start  = 0;
  endtask

  task automatic model_step();
    bit busy_pre;
    busy_pre = m_busy();
    case (address)
      2'd0:    m_rd = {24'd0, m_tx};
      2'd1:    m_rd = {30'd0, m_ovr, busy_pre};
      2'd2:    m_rd = {24'd0, m_divreg};
      default: m_rd = {31'd0, m_scs};
    endcase
    m_cyc++;
    if (chipselect && !write_n) begin
      case (address)
        2'd0: begin
          if (busy_pre) m_ovr = 1'b1;
          else begin
            m_active = 1'b1;
            m_start  = m_cyc;
            m_byte   = writedata[7:0];
            m_tx     = writedata[7:0];
            m_div    = (m_divreg == 8'd0) ? 1 : int'(m_divreg);
          end
        end
        2'd1:    if (writedata[1]) m_ovr = 1'b0;
        2'd2:    m_divreg = writedata[7:0];
        default: m_scs = writedata[0];
      endcase
    end
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // every-cycle compare of all DUT outputs against the model
  initial begin
    int   t;
    logic e_sck;
    logic e_sdi;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_busy()) begin
          t     = m_cyc - m_start;
          e_sck = ((t % (2 * m_div)) >= m_div);
          e_sdi = m_byte[3'(7 - t / (2 * m_div))];
        end else begin
          e_sck = 1'b0;
          e_sdi = 1'b1;
        end
        chk("cyc_sck", {31'd0, usb_sck}, {31'd0, e_sck});
        chk("cyc_sdi", {31'd0, usb_sdi}, {31'd0, e_sdi});
        chk("cyc_scs", {31'd0, usb_scs}, {31'd0, m_scs});
        chk("cyc_readdata", readdata, m_rd);
      end
    end
  end

  // ---------------- bus helpers ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      rd(2'd1, d);
      if (d[0] == 1'b0) ok = 1'b1;
    end
    chk({tag, "_idle_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  // send one byte and measure it from the pins: bits at sck rises, sck period, busy length
  task automatic xfer(input logic [7:0] b, input int exp_period, input int exp_busy, input string tag);
    logic [7:0] got;
    int   rises, first_r, second_r, busy_cnt;
    logic prev_sck;
    bit   done;
    wr(2'd0, {24'd0, b});
    address  = 2'd1;
    got      = 8'd0;
    rises    = 0;
    first_r  = -1;
    second_r = -1;
    busy_cnt = 0;
    done     = 1'b0;
    prev_sck = usb_sck;
    for (int i = 0; i < 9000 && !done; i++) begin
      if (!prev_sck && usb_sck) begin
        got = {got[6:0], usb_sdi};
        if (rises == 0) first_r = i;
        else if (rises == 1) second_r = i;
        rises++;
      end
      prev_sck = usb_sck;
      if (i >= 1) begin
        if (readdata[0]) busy_cnt++;
        else if (busy_cnt > 0) done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
    chk({tag, "_byte"}, {24'd0, got}, {24'd0, b});
    chk({tag, "_rises"}, rises, 32'd8);
    chk({tag, "_period"}, second_r - first_r, exp_period);
    chk({tag, "_busy"}, busy_cnt, exp_busy);
    chk({tag, "_sdi_idle"}, {31'd0, usb_sdi}, 32'd1);
    chk({tag, "_sck_idle"}, {31'd0, usb_sck}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random stimulus ----------------
  initial begin
    logic [31:0] d;
    #2;
    reset  = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_sck", {31'd0, usb_sck}, 32'd0);
    chk("rst_sdi", {31'd0, usb_sdi}, 32'd1);
    chk("rst_scs", {31'd0, usb_scs}, 32'd1);
    idle(3);
    reset = 1'b0;
    rd(2'd2, d); chk("rst_divider", d, 32'd4);
    rd(2'd1, d); chk("rst_status", d, 32'd0);

    // basic transfer at the default divider
    xfer(8'hA5, 8, 64, "a5_div4");

    // divider 0 behaves as 1
    wr(2'd2, 32'd0);
    xfer(8'h3C, 2, 16, "3c_div0");

    // slowest divider
    wr(2'd2, 32'd255);
    xfer(8'h96, 510, 4080, "96_div255");

    // overrun: second byte is dropped and flagged
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h11);
    idle(3);
    wr(2'd0, 32'h22);
    rd(2'd1, d); chk("ovr_status", d, 32'd3);
    rd(2'd0, d); chk("ovr_txdata", d, 32'h11);
    wr(2'd1, 32'h2);
    rd(2'd1, d); chk("ovr_clr_busy", d, 32'd1);
    wait_idle("ovr");
    rd(2'd1, d); chk("ovr_done", d, 32'd0);

    // chip-select is software-only and does not disturb the shift
    wr(2'd3, 32'd0);
    chk("scs_low", {31'd0, usb_scs}, 32'd0);
    wr(2'd0, 32'hFF);
    idle(10);
    wr(2'd3, 32'd1);
    chk("scs_high", {31'd0, usb_scs}, 32'd1);
    rd(2'd1, d); chk("scs_still_busy", d, 32'd1);
    wait_idle("scs");

    // reset in the middle of a byte
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h80);
    idle(25);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_sck", {31'd0, usb_sck}, 32'd0);
    chk("mid_rst_sdi", {31'd0, usb_sdi}, 32'd1);
    chk("mid_rst_scs", {31'd0, usb_scs}, 32'd1);
    chk("mid_rst_readdata", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, d); chk("mid_rst_status", d, 32'd0);
    xfer(8'h01, 8, 64, "01_after_rst");

    // random bus traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0;
      if (address == 2'd2) writedata = {24'($urandom), 8'($urandom_range(0, 6))};
      else writedata = $urandom;
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    wait_idle("rand");
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
